// File: rtl/uart_tx_pkg.sv
// Shared types and default constants for the UART transmitter.
package uart_tx_pkg;

  localparam int unsigned DATA_WIDTH   = 8;
  localparam int unsigned CLKS_PER_BIT = 8;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

endpackage

// File: rtl/uart_tx_if.sv
// Parallel request side and serial/status outputs of the UART transmitter.
interface uart_tx_if #(
  parameter int unsigned DATA_WIDTH = uart_tx_pkg::DATA_WIDTH
);

  logic [DATA_WIDTH-1:0] p_data;
  logic                  data_valid;
  logic                  par_en;
  logic                  par_typ;
  logic                  tx_out;
  logic                  busy;

  modport master (
    output p_data, data_valid, par_en, par_typ,
    input  tx_out, busy
  );

  modport slave (
    input  p_data, data_valid, par_en, par_typ,
    output tx_out, busy
  );

endinterface

// File: rtl/tx_serializer.sv
// LSB-first shift register with a bit index that stops at the last data bit.
module tx_serializer #(
  parameter int unsigned DATA_WIDTH = uart_tx_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic                  shift_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  next_bit_o,
  output logic                  done_o
);

  localparam int unsigned IdxW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [IdxW-1:0]       idx_q, idx_d;

  assign done_o = (idx_q == IdxW'(DATA_WIDTH - 1));

  always_comb begin
    shift_d = shift_q;
    idx_d   = idx_q;
    if (load_i) begin
      shift_d = data_i;
      idx_d   = '0;
    end else if (shift_i && !done_o) begin
      shift_d = shift_q >> 1;
      idx_d   = idx_q + IdxW'(1);
    end
  end

  // Bit that will be on the line after this edge; lets tx_out stay registered.
  assign next_bit_o = shift_d[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= '0;
      idx_q   <= '0;
    end else begin
      shift_q <= shift_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, stop bit.
module uart_tx #(
  parameter int unsigned DATA_WIDTH   = uart_tx_pkg::DATA_WIDTH,
  parameter int unsigned CLKS_PER_BIT = uart_tx_pkg::CLKS_PER_BIT
) (
  input logic      clk,
  input logic      rst,
  uart_tx_if.slave bus
);

  import uart_tx_pkg::*;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       par_en_q, par_en_d;
  logic       par_bit_q, par_bit_d;
  logic       tx_q, tx_d;
  logic       busy_q, busy_d;
  logic       bit_end;
  logic       load, shift;
  logic       ser_next_bit, ser_done;

  assign bit_end = (cnt_q == 8'(CLKS_PER_BIT - 1));

  tx_serializer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_serializer (
    .clk       (clk),
    .rst       (rst),
    .load_i    (load),
    .shift_i   (shift),
    .data_i    (bus.p_data),
    .next_bit_o(ser_next_bit),
    .done_o    (ser_done)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = bit_end ? 8'd0 : cnt_q + 8'd1;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    load      = 1'b0;
    shift     = 1'b0;

    unique case (state_q)
      StIdle: begin
        cnt_d = 8'd0;
        if (bus.data_valid) begin
          state_d   = StStart;
          load      = 1'b1;
          par_en_d  = bus.par_en;
          par_bit_d = (^bus.p_data) ^ bus.par_typ;
        end
      end
      StStart: if (bit_end) state_d = StData;
      StData: begin
        if (bit_end) begin
          if (ser_done) state_d = par_en_q ? StParity : StStop;
          else          shift   = 1'b1;
        end
      end
      StParity: if (bit_end) state_d = StStop;
      StStop:   if (bit_end) state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    // Outputs are decoded from the next state so they change on the same edge.
    busy_d = (state_d != StIdle);
    tx_d   = 1'b1;
    case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = ser_next_bit;
      StParity: tx_d = par_bit_q;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= 8'd0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.tx_out = tx_q;
  assign bus.busy   = busy_q;

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter DATA_WIDTH, default 8, payload bits per frame.
REQ-002 Parameter CLKS_PER_BIT, default 8, clk cycles per serial bit; legal range 2..255.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 p_data  input  DATA_WIDTH  parallel byte to transmit.
REQ-006 data_valid  input  1  request to send p_data; single-cycle or level.
REQ-007 par_en  input  1  1 = append a parity bit.
REQ-008 par_typ  input  1  0 = even parity, 1 = odd parity.
REQ-009 tx_out  output  1  serial line, registered, idle high.
REQ-010 busy  output  1  registered; high while a frame is in flight.

Function
REQ-011 The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP.
REQ-012 In IDLE, tx_out SHALL be 1 and busy SHALL be 0.
REQ-013 In IDLE, data_valid=1 SHALL accept the frame in that cycle and latch p_data, par_en and par_typ.
REQ-014 data_valid SHALL be ignored in every state other than IDLE; input changes mid-frame SHALL NOT affect the frame in flight.
REQ-015 tx_out SHALL go to 0 (start bit) and busy to 1 on the first clk edge after acceptance; latency is 1 cycle.
REQ-016 START, each DATA bit, PARITY and STOP SHALL each hold tx_out for exactly CLKS_PER_BIT cycles, timed by a bit-period counter that restarts at every bit boundary.
REQ-017 DATA SHALL send the latched byte LSB first over DATA_WIDTH bit periods, tracked by a bit index counter 0..DATA_WIDTH-1.
REQ-018 After the last data bit, the FSM SHALL go to PARITY if the latched par_en=1, otherwise directly to STOP.
REQ-019 The parity bit SHALL be the XOR of the latched data bits when par_typ=0 (even), and its inverse when par_typ=1 (odd).
REQ-020 STOP SHALL drive tx_out=1 and then return to IDLE; busy SHALL be high in every START, DATA, PARITY and STOP cycle.
REQ-021 Frame length SHALL be (2+DATA_WIDTH+par_en)*CLKS_PER_BIT cycles from the first start-bit cycle to the end of the stop bit.
REQ-022 Back-to-back: the earliest next acceptance SHALL be the first IDLE cycle after STOP, which gives exactly 1 extra idle-high cycle between frames when data_valid is held high.
REQ-023 The bit-period and bit-index counters SHALL NOT wrap past their terminal counts; terminal count SHALL coincide exactly with the state/bit transition.

Reset
REQ-024 With rst=1 at a clk edge, the state SHALL be IDLE, tx_out=1, busy=0, and the counters and shift register SHALL be 0, taking effect at that edge.
REQ-025 Reset asserted mid-frame SHALL abort the frame; tx_out=1 from the next edge, and no partial bits SHALL resume after rst falls.
REQ-026 data_valid=1 in the same cycle as rst=1 SHALL be ignored.

Structure
REQ-027 A shared package uart_tx_pkg SHALL hold the state enum (IDLE, START, DATA, PARITY, STOP) and the default constants DATA_WIDTH and CLKS_PER_BIT.
REQ-028 One sub-module, tx_serializer, SHALL hold the shift register and bit-index counter, with load, shift and done signals; the FSM, the bit-period counter and the parity logic SHALL live in uart_tx.

Verification
REQ-029 CLKS_PER_BIT=4, p_data=0xA5, par_en=1, par_typ=0 -> tx_out bits 0|1,0,1,0,0,1,0,1|0|1, each bit 4 cycles, busy high 44 cycles.
REQ-030 p_data=0x01, par_en=1, par_typ=1 -> parity bit 0; the same byte with par_typ=0 -> parity bit 1.
REQ-031 p_data=0xFF, par_en=0 -> 10-bit frame 0,1x8,1 lasting 40 cycles, with no parity period.
REQ-032 data_valid held high with p_data changed mid-frame -> first frame unaltered; second frame starts after exactly 1 idle-high cycle.
REQ-033 rst pulsed during DATA bit 3 -> tx_out=1 and busy=0 on the next edge; a later data_valid sends a clean full frame.
REQ-034 data_valid pulsed while busy=1 -> ignored; no extra frame is sent.
